// File: rtl/seq_alu_if.sv
// seq_alu_if
// Groups the start/busy/done handshake, the operand/opcode bus and the
// result/flag outputs of the sequential ALU.
//   start  : request a new operation (control unit -> ALU)
//   op     : 3-bit opcode (control unit -> ALU)
//   a, b   : WIDTH-bit unsigned operands (control unit -> ALU)
//   result : registered WIDTH-bit result (ALU -> control unit / datapath)
//   cf/sf/zf : carry, sign and zero flags (ALU -> flag register)
//   busy   : multiply in progress, start ignored while high
//   done   : one-cycle pulse when result and flags were updated
// The master modport belongs to the control unit; the slave modport belongs to the ALU.
interface seq_alu_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             cf;
    logic             sf;
    logic             zf;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b,
        input  result, cf, sf, zf, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output result, cf, sf, zf, busy, done
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu
// Multi-cycle ALU of the 6-bit CPU datapath, feeding the flag register.
// ADD, SUB, AND, OR, XOR, SHL and SHR finish on the edge that accepts start.
// MUL is an iterative shift-add multiply that runs for WIDTH clocks.
// Ports:
//   clk   : system clock, rising-edge active
//   rst_n : asynchronous active-low reset
//   alu   : seq_alu_if slave modport (start/op/a/b in; result/cf/sf/zf/busy/done out)
module seq_alu #(
    parameter int WIDTH = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_alu_if.slave   alu
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic                 w_lastStep;

    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CNT_W-1:0]     r_count;
    logic [2*WIDTH-1:0]   w_accNext;

    logic [WIDTH-1:0]     r_result;
    logic                 r_cf;
    logic                 r_sf;
    logic                 r_zf;
    logic                 r_done;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_opResult;
    logic                 w_opCarry;
    logic [WIDTH-1:0]     w_mulResult;
    logic                 w_mulOverflow;

    // State register; reset drops any multiply in flight straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Start is only honoured in IDLE, which is exactly when
    // busy is low, so a start during a multiply is dropped rather than queued.
    // The step at count WIDTH-1 is the final partial product.
    always_comb begin
        w_nextState = r_state;
        w_lastStep  = 1'b0;
        case (r_state)
            IDLE: begin
                if (alu.start && (alu.op == OP_MUL)) begin
                    w_nextState = MUL;
                end
            end
            MUL: begin
                if (r_count == LAST_STEP) begin
                    w_lastStep  = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Single-cycle operations, evaluated straight from the live inputs so they
    // can be written on the accepting edge. The extra top bit of the sum and
    // difference holds the carry out and the borrow (set iff a < b).
    always_comb begin
        w_sum      = {1'b0, alu.a} + {1'b0, alu.b};
        w_diff     = {1'b0, alu.a} - {1'b0, alu.b};
        w_opResult = '0;
        w_opCarry  = 1'b0;
        case (alu.op)
            OP_ADD: begin
                w_opResult = w_sum[WIDTH-1:0];
                w_opCarry  = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_opResult = w_diff[WIDTH-1:0];
                w_opCarry  = w_diff[WIDTH];
            end
            OP_AND: w_opResult = alu.a & alu.b;
            OP_OR:  w_opResult = alu.a | alu.b;
            OP_XOR: w_opResult = alu.a ^ alu.b;
            OP_SHL: begin
                w_opResult = {alu.a[WIDTH-2:0], 1'b0};
                w_opCarry  = alu.a[WIDTH-1];
            end
            OP_SHR: begin
                w_opResult = {1'b0, alu.a[WIDTH-1:1]};
                w_opCarry  = alu.a[0];
            end
            default: begin
                w_opResult = '0;
                w_opCarry  = 1'b0;
            end
        endcase
    end

    // One shift-add step: the multiplicand is pre-shifted so the current
    // multiplier LSB decides whether it joins the accumulator. On the last
    // step this value is the complete product, so it is used directly.
    always_comb begin
        w_accNext     = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_mulResult   = w_accNext[WIDTH-1:0];
        w_mulOverflow = |w_accNext[2*WIDTH-1:WIDTH];
    end

    // Datapath and output registers. Result and flags only change on an
    // accepted single-cycle op or the final multiply step, and done pulses on
    // exactly those edges; otherwise everything holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_cf     <= 1'b0;
            r_sf     <= 1'b0;
            r_zf     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == IDLE) && alu.start) begin
                if (alu.op == OP_MUL) begin
                    r_acc    <= '0;
                    r_mcand  <= {{WIDTH{1'b0}}, alu.a};
                    r_mplier <= alu.b;
                    r_count  <= '0;
                end else begin
                    r_result <= w_opResult;
                    r_cf     <= w_opCarry;
                    r_sf     <= w_opResult[WIDTH-1];
                    r_zf     <= (w_opResult == '0);
                    r_done   <= 1'b1;
                end
            end else if (r_state == MUL) begin
                r_acc    <= w_accNext;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + 1'b1;
                if (w_lastStep) begin
                    r_result <= w_mulResult;
                    r_cf     <= w_mulOverflow;
                    r_sf     <= w_mulResult[WIDTH-1];
                    r_zf     <= (w_mulResult == '0);
                    r_done   <= 1'b1;
                end
            end
        end
    end

    // Busy comes straight from the registered state, so it is glitch-free.
    always_comb begin
        alu.result = r_result;
        alu.cf     = r_cf;
        alu.sf     = r_sf;
        alu.zf     = r_zf;
        alu.done   = r_done;
        alu.busy   = (r_state == MUL);
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu
// Directed self-checking bench for seq_alu. Inputs are driven and outputs
// sampled 1 ns after each rising edge, away from the active edge.
module tb_seq_alu;
    localparam int WIDTH = 6;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   doneCount;

    seq_alu_if #(.WIDTH(WIDTH)) aluIf ();

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .alu   (aluIf.slave)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the request side of the interface.
    task automatic applyStimulus(input logic st, input logic [2:0] opc,
                                 input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        aluIf.start = st;
        aluIf.op    = opc;
        aluIf.a     = va;
        aluIf.b     = vb;
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the full output bundle {result, cf, sf, zf, busy, done}.
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] expRes,
                               input logic expCf, input logic expSf, input logic expZf,
                               input logic expBusy, input logic expDone);
        logic [WIDTH+4:0] observed;
        logic [WIDTH+4:0] expected;
        observed = {aluIf.result, aluIf.cf, aluIf.sf, aluIf.zf, aluIf.busy, aluIf.done};
        expected = {expRes, expCf, expSf, expZf, expBusy, expDone};
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed res=%0d cf=%b sf=%b zf=%b busy=%b done=%b, expected res=%0d cf=%b sf=%b zf=%b busy=%b done=%b",
                   tag, aluIf.result, aluIf.cf, aluIf.sf, aluIf.zf, aluIf.busy, aluIf.done,
                   expRes, expCf, expSf, expZf, expBusy, expDone);
        end
    endtask

    // Compare a plain integer count.
    task automatic checkCount(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Linear sequence of directed steps with hand-computed expectations.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        applyStimulus(1'b0, OP_ADD, '0, '0);
        repeat (2) tick();
        checkOutput("reset", 6'd0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_after_reset", 6'd0, 0, 0, 0, 0, 0);

        // ADD 63+1 -> 0 with carry out
        applyStimulus(1'b1, OP_ADD, 6'd63, 6'd1);
        tick();
        applyStimulus(1'b0, OP_ADD, '0, '0);
        checkOutput("add_63_1", 6'd0, 1, 0, 1, 0, 1);
        tick();
        checkOutput("add_hold", 6'd0, 1, 0, 1, 0, 0);

        // SUB 5-9 -> 60 with borrow, then AND issued in the done cycle
        applyStimulus(1'b1, OP_SUB, 6'd5, 6'd9);
        tick();
        checkOutput("sub_5_9", 6'd60, 1, 1, 0, 0, 1);
        applyStimulus(1'b1, OP_AND, 6'b101010, 6'b010101);
        tick();
        applyStimulus(1'b0, OP_ADD, '0, '0);
        checkOutput("and_b2b", 6'd0, 0, 0, 1, 0, 1);
        tick();
        checkOutput("and_hold", 6'd0, 0, 0, 1, 0, 0);

        // MUL 7*9 = 63
        applyStimulus(1'b1, OP_MUL, 6'd7, 6'd9);
        tick();
        applyStimulus(1'b0, OP_ADD, '0, '0);
        checkOutput("mul79_t0", 6'd0, 0, 0, 1, 1, 0);
        for (int i = 1; i < WIDTH; i++) begin
            tick();
            checkOutput("mul79_running", 6'd0, 0, 0, 1, 1, 0);
        end
        tick();
        checkOutput("mul79_done", 6'd63, 0, 1, 0, 0, 1);

        // Back-to-back MUL 8*8 = 64 started in the done cycle
        applyStimulus(1'b1, OP_MUL, 6'd8, 6'd8);
        tick();
        applyStimulus(1'b0, OP_ADD, '0, '0);
        checkOutput("mul88_t0", 6'd63, 0, 1, 0, 1, 0);
        repeat (WIDTH - 1) tick();
        checkOutput("mul88_last_busy", 6'd63, 0, 1, 0, 1, 0);
        tick();
        checkOutput("mul88_done", 6'd0, 1, 0, 1, 0, 1);

        // MUL 3*3 with an ADD start pulsed while busy: must be ignored
        tick();
        applyStimulus(1'b1, OP_MUL, 6'd3, 6'd3);
        tick();
        applyStimulus(1'b0, OP_ADD, '0, '0);
        doneCount = 0;
        tick();
        if (aluIf.done) doneCount++;
        applyStimulus(1'b1, OP_ADD, 6'd1, 6'd1);
        tick();
        if (aluIf.done) doneCount++;
        applyStimulus(1'b0, OP_ADD, '0, '0);
        checkOutput("mul33_ignore_start", 6'd0, 1, 0, 1, 1, 0);
        repeat (WIDTH - 3) begin
            tick();
            if (aluIf.done) doneCount++;
        end
        tick();
        if (aluIf.done) doneCount++;
        checkOutput("mul33_done", 6'd9, 0, 0, 0, 0, 1);
        repeat (3) begin
            tick();
            if (aluIf.done) doneCount++;
        end
        checkOutput("mul33_no_queued_add", 6'd9, 0, 0, 0, 0, 0);
        checkCount("mul33_done_pulses", doneCount, 1);

        // Shifts
        applyStimulus(1'b1, OP_SHL, 6'b100001, 6'd0);
        tick();
        checkOutput("shl", 6'b000010, 1, 0, 0, 0, 1);
        applyStimulus(1'b1, OP_SHR, 6'b000001, 6'd0);
        tick();
        applyStimulus(1'b0, OP_ADD, '0, '0);
        checkOutput("shr", 6'd0, 1, 0, 1, 0, 1);
        tick();

        // Asynchronous reset after the third MUL step
        applyStimulus(1'b1, OP_MUL, 6'd5, 6'd5);
        tick();
        applyStimulus(1'b0, OP_ADD, '0, '0);
        repeat (3) tick();
        checkOutput("mul55_step3", 6'd0, 1, 0, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 6'd0, 0, 0, 0, 0, 0);
        doneCount = 0;
        repeat (2) begin
            tick();
            if (aluIf.done) doneCount++;
        end
        rst_n = 1'b1;
        repeat (WIDTH) begin
            tick();
            if (aluIf.done) doneCount++;
        end
        checkCount("abort_no_done", doneCount, 0);
        checkOutput("abort_idle", 6'd0, 0, 0, 0, 0, 0);

        // ADD 2+3 after reset recovery
        applyStimulus(1'b1, OP_ADD, 6'd2, 6'd3);
        tick();
        applyStimulus(1'b0, OP_ADD, '0, '0);
        checkOutput("add_2_3", 6'd5, 0, 0, 0, 0, 1);
        tick();
        checkOutput("add_2_3_hold", 6'd5, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
